// File: rtl/result_uploader.sv
// rtl/result_uploader.sv - uploads matrix-multiply result elements and the final tick count
//
// Purpose: serves result elements from a synchronous-read result RAM over a
// valid/ready stream. It is driven by a four-phase handshake with the collector.
// After the collector reports completion it sends one tick-count word.
//
// Ports:
//   clk, reset_n          clock and synchronous active-low reset
//   start_mm              clears and starts the tick counter and element count
//   elem_rdy, r, c, a3    element request and its row, column and column count
//   mm_done               collector finished; triggers the tick-count word
//   ack_elem, ack_ticks   idle-high four-phase acknowledges
//   rd_en, rd_addr        result RAM read request (data returns one cycle later)
//   rd_data               result RAM read data
//   out_valid/data/tag    upload stream (tag 0 = element, tag 1 = tick count)
//   out_ready             downstream accept
//   elem_cnt              elements uploaded since the last start_mm
module result_uploader #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start_mm,
  input  logic          elem_rdy,
  input  logic          mm_done,
  input  logic [4:0]    r,
  input  logic [4:0]    c,
  input  logic [4:0]    a3,
  output logic          ack_elem,
  output logic          ack_ticks,
  output logic          rd_en,
  output logic [9:0]    rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_tag,
  input  logic          out_ready,
  output logic [9:0]    elem_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    E_RD   = 3'd1,
    E_WAIT = 3'd2,
    E_SEND = 3'd3,
    E_ACK  = 3'd4,
    T_LOAD = 3'd5,
    T_SEND = 3'd6,
    T_ACK  = 3'd7
  } state_t;

  state_t      state;
  logic [31:0] tick_cnt;
  logic        running;
  logic [9:0]  addr_calc;

  // The operands are widened to 10 bits before the multiply. This keeps the full
  // product. The largest address is 31*31+30 = 991, so the sum always fits.
  assign addr_calc = ({5'd0, r} * {5'd0, a3}) + {5'd0, c};

  // The tick counter runs from start_mm until the edge where mm_done is first
  // seen. That edge still counts.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tick_cnt <= 32'd0;
      running  <= 1'b0;
    end else if (start_mm) begin
      tick_cnt <= 32'd0;
      running  <= 1'b1;
    end else if (running) begin
      if (tick_cnt != 32'hFFFF_FFFF)
        tick_cnt <= tick_cnt + 32'd1;
      if (mm_done)
        running <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      ack_elem  <= 1'b1;
      ack_ticks <= 1'b1;
      rd_en     <= 1'b0;
      rd_addr   <= 10'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= 1'b0;
      elem_cnt  <= 10'd0;
    end else begin
      case (state)
        IDLE: begin
          if (elem_rdy) begin
            ack_elem <= 1'b0;
            rd_en    <= 1'b1;
            rd_addr  <= addr_calc;
            state    <= E_RD;
          end else if (mm_done) begin
            ack_ticks <= 1'b0;
            state     <= T_LOAD;
          end
        end
        E_RD: begin
          rd_en <= 1'b0;
          state <= E_WAIT;
        end
        E_WAIT: begin
          out_data  <= rd_data;
          out_tag   <= 1'b0;
          out_valid <= 1'b1;
          state     <= E_SEND;
        end
        E_SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            ack_elem  <= 1'b1;
            elem_cnt  <= elem_cnt + 10'd1;
            state     <= E_ACK;
          end
        end
        E_ACK: begin
          if (!elem_rdy)
            state <= IDLE;
        end
        T_LOAD: begin
          out_data  <= DW'(tick_cnt);
          out_tag   <= 1'b1;
          out_valid <= 1'b1;
          state     <= T_SEND;
        end
        T_SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            ack_ticks <= 1'b1;
            state     <= T_ACK;
          end
        end
        T_ACK: begin
          if (!mm_done)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // A restart clears the count even on the same edge as an upload handshake.
      if (start_mm)
        elem_cnt <= 10'd0;
    end
  end

endmodule

// File: tb/tb_result_uploader.sv
// tb/tb_result_uploader.sv - directed self-checking bench for result_uploader
module tb_result_uploader;

  logic        clk;
  logic        reset_n;
  logic        start_mm;
  logic        elem_rdy;
  logic        mm_done;
  logic [4:0]  r;
  logic [4:0]  c;
  logic [4:0]  a3;
  logic        ack_elem;
  logic        ack_ticks;
  logic        rd_en;
  logic [9:0]  rd_addr;
  logic [31:0] rd_data;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_tag;
  logic        out_ready;
  logic [9:0]  elem_cnt;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:1023];

  result_uploader #(.DW(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start_mm  (start_mm),
    .elem_rdy  (elem_rdy),
    .mm_done   (mm_done),
    .r         (r),
    .c         (c),
    .a3        (a3),
    .ack_elem  (ack_elem),
    .ack_ticks (ack_ticks),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_ready (out_ready),
    .elem_cnt  (elem_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model with one cycle of synchronous read latency.
  always @(posedge clk) begin
    if (rd_en)
      rd_data <= mem[rd_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[0]   = 32'h0000_1111;
    mem[5]   = 32'h0000_ABCD;
    mem[991] = 32'h1234_5678;
    rd_data   = 32'h0;
    reset_n   = 1'b0;
    start_mm  = 1'b0;
    elem_rdy  = 1'b0;
    mm_done   = 1'b0;
    r = 5'd0; c = 5'd0; a3 = 5'd0;
    out_ready = 1'b0;

    // Reset state
    step(); step();
    reset_n = 1'b1;
    check("rst_ack_elem",  ack_elem,  1);
    check("rst_ack_ticks", ack_ticks, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_rd_en",     rd_en,     0);
    check("rst_rd_addr",   rd_addr,   0);
    check("rst_out_data",  out_data,  0);
    check("rst_out_tag",   out_tag,   0);
    check("rst_elem_cnt",  elem_cnt,  0);
    check("rst_state",     dut.state, 0);

    // Element path: addr 1*3+2 = 5
    a3 = 5'd3; r = 5'd1; c = 5'd2; out_ready = 1'b1; elem_rdy = 1'b1;
    step();
    check("e_ack_low",   ack_elem, 0);
    check("e_rd_addr",   rd_addr,  5);
    check("e_rd_en",     rd_en,    1);
    step();
    check("e_rd_en_off", rd_en,     0);
    check("e_nvalid",    out_valid, 0);
    step();
    check("e_valid",     out_valid, 1);
    check("e_data",      out_data,  32'hABCD);
    check("e_tag",       out_tag,   0);
    step();
    check("e_ack_high",  ack_elem,  1);
    check("e_cnt1",      elem_cnt,  1);
    check("e_valid_off", out_valid, 0);
    step();
    check("e_hold_ack",  dut.state, 4);
    check("e_no_reread", rd_en,     0);
    elem_rdy = 1'b0;
    step();
    check("e_idle",      dut.state, 0);

    // Backpressure: addr 0, out_ready low for 5 cycles in E_SEND
    r = 5'd0; c = 5'd0; out_ready = 1'b0; elem_rdy = 1'b1;
    step(); step(); step();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", out_valid, 1);
      check("bp_data",  out_data,  32'h1111);
      check("bp_ack",   ack_elem,  0);
      step();
    end
    check("bp_valid_last", out_valid, 1);
    out_ready = 1'b1;
    step();
    check("bp_ack_rise", ack_elem,  1);
    check("bp_valid_off", out_valid, 0);
    check("bp_cnt2",     elem_cnt,  2);
    elem_rdy = 1'b0;
    step();

    // Max address: 31*31+30 = 991
    a3 = 5'd31; r = 5'd31; c = 5'd30; elem_rdy = 1'b1;
    step();
    check("max_addr", rd_addr, 991);
    step(); step();
    check("max_data", out_data, 32'h1234_5678);
    step();
    check("max_cnt3", elem_cnt, 3);
    elem_rdy = 1'b0;
    step();

    // Reset held for 2 cycles while in E_SEND
    a3 = 5'd3; r = 5'd1; c = 5'd2; out_ready = 1'b0; elem_rdy = 1'b1;
    step(); step(); step();
    check("rs_in_send", dut.state, 3);
    reset_n = 1'b0; elem_rdy = 1'b0;
    step(); step();
    reset_n = 1'b1;
    check("rs_ack_elem",  ack_elem,  1);
    check("rs_ack_ticks", ack_ticks, 1);
    check("rs_valid",     out_valid, 0);
    check("rs_state",     dut.state, 0);
    check("rs_cnt",       elem_cnt,  0);
    step();
    check("rs_stay_idle", out_valid, 0);

    // Tick word: start_mm at K, mm_done from K+100 gives 100
    out_ready = 1'b1;
    start_mm = 1'b1;
    step();
    start_mm = 1'b0;
    for (int i = 0; i < 99; i++) step();
    check("t_ack_idle", ack_ticks, 1);
    mm_done = 1'b1;
    step();
    check("t_ack_low",  ack_ticks, 0);
    step();
    check("t_valid",    out_valid, 1);
    check("t_data",     out_data,  100);
    check("t_tag",      out_tag,   1);
    step();
    check("t_ack_high", ack_ticks, 1);
    check("t_valid_off", out_valid, 0);
    step(); step();
    check("t_no_extra", out_valid, 0);
    check("t_hold",     dut.state, 7);
    mm_done = 1'b0;
    step();
    check("t_idle",     dut.state, 0);

    // start_mm on the same edge as an element handshake clears elem_cnt
    elem_rdy = 1'b1;
    step(); step(); step();
    check("sc_valid", out_valid, 1);
    check("sc_cnt_before", elem_cnt, 0);
    start_mm = 1'b1;
    step();
    start_mm = 1'b0;
    check("sc_cnt_clear", elem_cnt, 0);
    check("sc_ack",       ack_elem, 1);
    elem_rdy = 1'b0;
    step();

    // Ordering: element before tick word; tick_cnt = 1 at the stop edge
    start_mm = 1'b1;
    step();
    start_mm = 1'b0;
    elem_rdy = 1'b1; mm_done = 1'b1;
    step();
    check("o_ack_elem",  ack_elem,  0);
    check("o_ack_ticks", ack_ticks, 1);
    step(); step();
    check("o_e_valid",   out_valid, 1);
    check("o_e_tag",     out_tag,   0);
    check("o_e_data",    out_data,  32'hABCD);
    step();
    check("o_e_cnt",     elem_cnt,  1);
    elem_rdy = 1'b0;
    step();
    step();
    check("o_t_ack_low", ack_ticks, 0);
    step();
    check("o_t_valid",   out_valid, 1);
    check("o_t_tag",     out_tag,   1);
    check("o_t_data",    out_data,  1);
    step();
    check("o_t_ack_high", ack_ticks, 1);
    mm_done = 1'b0;
    step();
    check("o_idle",      dut.state, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/result_uploader.md
RESULT_UPLOADER -- requirements
Module: result_uploader

Interface
REQ-001 Parameter: DW, default 32, output data width; SHALL be at least 32 so the tick word fits.
REQ-002 Port: clk  input  1  clock; all logic on the rising edge.
REQ-003 Port: reset_n  input  1  synchronous, active-low reset.
REQ-004 Port: start_mm  input  1  start of a matrix multiply; clears and starts the tick counter.
REQ-005 Port: elem_rdy  input  1  collector holds a result element at (r,c).
REQ-006 Port: mm_done  input  1  collector has finished all elements.
REQ-007 Port: r, c  input  5 each  element row and column; stable while elem_rdy=1.
REQ-008 Port: a3  input  5  result column count (1..31).
REQ-009 Port: ack_elem  output  1  element acknowledge; idle-high four-phase.
REQ-010 Port: ack_ticks  output  1  done acknowledge; idle-high four-phase.
REQ-011 Port: rd_en, rd_addr  output  1, 10  result RAM read request and address; the RAM has 1-cycle synchronous read latency.
REQ-012 Port: rd_data  input  DW  RAM read data, valid the cycle after the rd_en edge.
REQ-013 Port: out_valid, out_data, out_tag  output  1, DW, 1  upload stream; tag 0 means element, tag 1 means tick count.
REQ-014 Port: out_ready  input  1  downstream accept.
REQ-015 Port: elem_cnt  output  10  elements uploaded since the last start_mm.

Function
REQ-016 All outputs SHALL be registered.
REQ-017 FSM states: IDLE, E_RD, E_WAIT, E_SEND, E_ACK, T_LOAD, T_SEND, T_ACK.
REQ-018 IDLE transitions:
- elem_rdy=1 -> E_RD: ack_elem<=0, rd_en<=1, rd_addr<=r*a3+c.
- else mm_done=1 -> T_LOAD: ack_ticks<=0.
- elem_rdy has priority over mm_done.
REQ-019 rd_addr arithmetic: full-precision 10-bit product plus sum, no truncation; maximum is 31*31+30=991.
REQ-020 E_RD -> E_WAIT: rd_en<=0.
REQ-021 E_WAIT -> E_SEND: out_data<=rd_data, out_tag<=0, out_valid<=1.
REQ-022 E_SEND:
- out_valid, out_data and out_tag held until out_ready=1.
- On out_ready=1: out_valid<=0, ack_elem<=1, elem_cnt+=1 (wraps at 1024), go to E_ACK.
REQ-023 E_ACK: stay until elem_rdy=0, then go to IDLE. A new element is never accepted before elem_rdy has dropped.
REQ-024 T_LOAD: out_data<=zero-extended tick_cnt, out_tag<=1, out_valid<=1, go to T_SEND.
REQ-025 T_SEND: on out_ready=1: out_valid<=0, ack_ticks<=1, go to T_ACK.
REQ-026 T_ACK: stay until mm_done=0, then go to IDLE.
REQ-027 ack_elem=0 only in E_RD, E_WAIT and E_SEND. ack_ticks=0 only in T_LOAD and T_SEND.
REQ-028 Latency: elem_rdy sampled at edge N gives ack_elem=0 after N and out_valid=1 after N+2.
REQ-029 Tick counter, 32-bit internal tick_cnt:
- start_mm=1 at any edge: tick_cnt<=0, running<=1, elem_cnt<=0. The FSM state is unaffected.
- Each edge with running=1 and start_mm=0: tick_cnt+=1, saturating at 0xFFFFFFFF.
- If mm_done=1 at that edge: running<=0, including the final increment.
REQ-030 start_mm coincident with an E_SEND handshake: the clear wins and elem_cnt=0.
REQ-031 out_valid SHALL never drop without out_ready, except on reset.

Reset
REQ-032 reset_n=0 at an edge gives:
- state=IDLE, ack_elem=1, ack_ticks=1
- rd_en=0, rd_addr=0
- out_valid=0, out_data=0, out_tag=0
- elem_cnt=0, tick_cnt=0, running=0
REQ-033 Reset mid-transfer discards the pending element or tick word. It is applied from any state and has priority over all inputs.

Verification
REQ-034 Reset: assert reset_n=0 for 2 cycles in E_SEND -> next cycle ack_elem=1, ack_ticks=1, out_valid=0, state IDLE.
REQ-035 Element path: a3=3, r=1, c=2, RAM[5]=0xABCD, elem_rdy=1 at edge N, out_ready=1 ->
- after N: ack_elem=0, rd_addr=5.
- after N+2: out_valid=1, out_data=0xABCD, out_tag=0.
- after N+3: ack_elem=1, elem_cnt=1.
- elem_rdy drop -> IDLE.
REQ-036 Backpressure: out_ready=0 for 5 cycles in E_SEND -> out_valid=1 and data stable, ack_elem=0 throughout; ack_elem rises 1 cycle after out_ready=1.
REQ-037 Max address: a3=31, r=31, c=30 -> rd_addr=991.
REQ-038 Ticks: start_mm at edge K, mm_done=1 from edge K+100 -> tick word out_data=100 with out_tag=1; ack_ticks 1->0->1; no extra words.
REQ-039 Ordering: elem_rdy and mm_done both high in IDLE -> element uploaded first, tick word after mm_done remains high.
